// File: rtl/sdram_responder.sv
// -----------------------------------------------------------------------------
// sdram_responder
//   Board-side model of a single SDR SDRAM (MT48LC16M16-style pins). Decodes
//   the controller's command stream, keeps a small on-chip backing array,
//   returns read data at the programmed CAS latency and latches the first
//   protocol violation it sees.
//
// Ports
//   clk            memory clock, all pins sampled on the rising edge
//   reset_n        asynchronous active-low reset
//   SDRAM_DQ       16-bit data bus, driven only during read data slots
//   SDRAM_A/BA     multiplexed address / bank select
//   SDRAM_DQML/H   write byte masks (1 = byte not written)
//   SDRAM_nCS/nRAS/nCAS/nWE/CKE  command pins
//   mode_reg       last accepted LOAD_MODE value
//   initialized    init sequence (PRECHARGE-all then LOAD_MODE) complete
//   err/err_code   sticky error flag and code of the first violation
//   refresh_count  saturating AUTO_REFRESH count
// -----------------------------------------------------------------------------
module sdram_responder #(
  parameter int ROW_BITS = 13,
  parameter int COL_BITS = 9,
  parameter int MEM_AW   = 12,
  parameter int TRCD     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  inout  wire  [15:0] SDRAM_DQ,
  input  logic [12:0] SDRAM_A,
  input  logic [1:0]  SDRAM_BA,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic        SDRAM_CKE,
  output logic [12:0] mode_reg,
  output logic        initialized,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] refresh_count
);

  // {nRAS,nCAS,nWE}
  localparam logic [2:0] C_LDM = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_BST = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

  localparam logic [1:0] S_WAIT_PRE = 2'd0;
  localparam logic [1:0] S_WAIT_LDM = 2'd1;
  localparam logic [1:0] S_READY    = 2'd2;

  // Read pipeline holds up to CL=7 slots (indices 0..STAGES).
  localparam int STAGES = 6;

  // Counter is loaded with TRCD-1 so that it reads zero exactly TRCD edges
  // after ACTIVE, which is when READ/WRITE becomes legal.
  localparam int         TRCD_LD_I = (TRCD > 0) ? TRCD - 1 : 0;
  localparam logic [7:0] TRCD_LD   = 8'(TRCD_LD_I);

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic [2:0] w_cmd;
  logic       w_act, w_rd, w_wr, w_pre, w_ref, w_ldm;
  logic       w_a10;

  assign w_cmd = {SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE};
  assign w_a10 = SDRAM_A[10];

  always_comb begin
    w_act = 1'b0;
    w_rd  = 1'b0;
    w_wr  = 1'b0;
    w_pre = 1'b0;
    w_ref = 1'b0;
    w_ldm = 1'b0;
    if (!SDRAM_nCS && SDRAM_CKE) begin
      case (w_cmd)
        C_ACT:   w_act = 1'b1;
        C_RD:    w_rd  = 1'b1;
        C_WR:    w_wr  = 1'b1;
        C_PRE:   w_pre = 1'b1;
        C_REF:   w_ref = 1'b1;
        C_LDM:   w_ldm = 1'b1;
        C_BST,
        C_NOP:   ;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0]          r_open;
  logic [ROW_BITS-1:0] r_row  [4];
  logic [7:0]          r_trcd [4];
  logic [1:0]          r_state;
  logic [12:0]         r_mode;
  logic                r_err;
  logic [2:0]          r_code;
  logic [15:0]         r_refcnt;
  logic [STAGES:0]        r_vld_pipe;
  logic [STAGES:0][15:0]  r_dat_pipe;
  logic [15:0]         r_mem [2**MEM_AW];

  logic                w_ready;
  logic                w_bank_open;
  logic                w_mode_bad;
  logic [MEM_AW-1:0]   w_idx;
  logic [15:0]         w_rdata;
  logic [15:0]         w_dq_in;
  logic [2:0]          w_ins;
  logic                w_err_hit;
  logic [2:0]          w_err_val;
  logic [STAGES:0]       w_vld_nxt;
  logic [STAGES:0][15:0] w_dat_nxt;

  assign w_ready     = (r_state == S_READY);
  assign w_bank_open = r_open[SDRAM_BA];
  // Only CL 2/3 with burst length 1 is supported.
  assign w_mode_bad  = !((SDRAM_A[6:4] == 3'd2) || (SDRAM_A[6:4] == 3'd3)) ||
                       (SDRAM_A[2:0] != 3'd0);

  // Array index is the low bits of {bank, open row, column}.
  assign w_idx   = MEM_AW'({SDRAM_BA, r_row[SDRAM_BA], SDRAM_A[COL_BITS-1:0]});
  assign w_rdata = r_mem[w_idx];
  assign w_dq_in = SDRAM_DQ;

  // Read data is inserted CL-1 slots up the pipeline so it reaches slot 0
  // (the bus driver) right after edge T+CL-1. CL 0 behaves as CL 1.
  assign w_ins = (r_mode[6:4] == 3'd0) ? 3'd0 : r_mode[6:4] - 3'd1;

  assign SDRAM_DQ = r_vld_pipe[0] ? r_dat_pipe[0] : 16'hzzzz;

  // ---------------------------------------------------------------------------
  // Protocol checks (lowest code wins when several apply to one command)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_err_hit = 1'b0;
    w_err_val = 3'd0;
    if (w_act) begin
      if (!w_ready)         begin w_err_hit = 1'b1; w_err_val = 3'd1; end
      else if (w_bank_open) begin w_err_hit = 1'b1; w_err_val = 3'd2; end
    end else if (w_rd || w_wr) begin
      if (!w_ready)                        begin w_err_hit = 1'b1; w_err_val = 3'd1; end
      else if (!w_bank_open)               begin w_err_hit = 1'b1; w_err_val = 3'd3; end
      else if (r_trcd[SDRAM_BA] != 8'd0)   begin w_err_hit = 1'b1; w_err_val = 3'd4; end
      else if (w_wr && (|r_vld_pipe))      begin w_err_hit = 1'b1; w_err_val = 3'd7; end
    end else if (w_ref) begin
      if (|r_open)          begin w_err_hit = 1'b1; w_err_val = 3'd5; end
    end else if (w_ldm) begin
      if (|r_open)          begin w_err_hit = 1'b1; w_err_val = 3'd5; end
      else if (w_mode_bad)  begin w_err_hit = 1'b1; w_err_val = 3'd6; end
    end
  end

  // ---------------------------------------------------------------------------
  // Bank state: open flag, open row, tRCD counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_open <= '0;
      for (int b = 0; b < 4; b++) begin
        r_row[b]  <= '0;
        r_trcd[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_act && (SDRAM_BA == 2'(b))) begin
          r_open[b] <= 1'b1;
          r_row[b]  <= SDRAM_A[ROW_BITS-1:0];
          r_trcd[b] <= TRCD_LD;
        end else begin
          if (r_trcd[b] != 8'd0) r_trcd[b] <= r_trcd[b] - 8'd1;
          // auto-precharge closes the bank after the access itself
          if ((w_rd || w_wr) && w_a10 && (SDRAM_BA == 2'(b))) r_open[b] <= 1'b0;
          if (w_pre && (w_a10 || (SDRAM_BA == 2'(b))))        r_open[b] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Init FSM, mode register, error latch, refresh counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_WAIT_PRE;
      r_mode   <= '0;
      r_err    <= 1'b0;
      r_code   <= '0;
      r_refcnt <= '0;
    end else begin
      case (r_state)
        S_WAIT_PRE: if (w_pre && w_a10) r_state <= S_WAIT_LDM;
        S_WAIT_LDM: if (w_ldm && !w_err_hit) r_state <= S_READY;
        S_READY:    ;
        default:    r_state <= S_WAIT_PRE;
      endcase

      if (w_ldm && !w_mode_bad) r_mode <= SDRAM_A;

      if (w_ref && (r_refcnt != 16'hFFFF)) r_refcnt <= r_refcnt + 16'd1;

      if (w_err_hit && !r_err) begin
        r_err  <= 1'b1;
        r_code <= w_err_val;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data pipeline (slot 0 drives the bus)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_vld_nxt = {1'b0, r_vld_pipe[STAGES:1]};
    w_dat_nxt = {16'h0000, r_dat_pipe[STAGES:1]};
    if (w_rd) begin
      w_vld_nxt[w_ins] = 1'b1;
      w_dat_nxt[w_ins] = w_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe <= w_vld_nxt;
      r_dat_pipe <= w_dat_nxt;
    end
  end

  // Backing array: no reset so contents survive reset_n.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      if (!SDRAM_DQML) r_mem[w_idx][7:0]  <= w_dq_in[7:0];
      if (!SDRAM_DQMH) r_mem[w_idx][15:8] <= w_dq_in[15:8];
    end
  end

  assign mode_reg      = r_mode;
  assign initialized   = w_ready;
  assign err           = r_err;
  assign err_code      = r_code;
  assign refresh_count = r_refcnt;

endmodule

// File: tb/tb_sdram_responder.sv
// -----------------------------------------------------------------------------
// tb_sdram_responder
//   Directed bench for sdram_responder: init, write/read at CL2 and CL3,
//   byte masks, back-to-back reads, refresh counting, error latching and
//   asynchronous reset in the middle of a read.
// -----------------------------------------------------------------------------
module tb_sdram_responder;

  localparam logic [2:0] LDM = 3'b000;
  localparam logic [2:0] REF = 3'b001;
  localparam logic [2:0] PRE = 3'b010;
  localparam logic [2:0] ACT = 3'b011;
  localparam logic [2:0] WR  = 3'b100;
  localparam logic [2:0] RD  = 3'b101;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] a = '0;
  logic [1:0]  ba = '0;
  logic        dqml = 1'b0, dqmh = 1'b0;
  logic        ncs = 1'b1, nras = 1'b1, ncas = 1'b1, nwe = 1'b1;
  logic        cke = 1'b1;
  logic [15:0] tb_dq = '0;
  logic        tb_oe = 1'b0;
  wire  [15:0] dq;

  logic [12:0] mode_reg;
  logic        initialized, err;
  logic [2:0]  err_code;
  logic [15:0] refresh_count;

  int total = 0;
  int bad   = 0;

  assign dq = tb_oe ? tb_dq : 16'hzzzz;

  always #5 clk = ~clk;

  sdram_responder dut (
    .clk(clk), .reset_n(reset_n), .SDRAM_DQ(dq), .SDRAM_A(a), .SDRAM_BA(ba),
    .SDRAM_DQML(dqml), .SDRAM_DQMH(dqmh), .SDRAM_nCS(ncs), .SDRAM_nRAS(nras),
    .SDRAM_nCAS(ncas), .SDRAM_nWE(nwe), .SDRAM_CKE(cke), .mode_reg(mode_reg),
    .initialized(initialized), .err(err), .err_code(err_code),
    .refresh_count(refresh_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus must not be carrying the given read word (released or not yet driven).
  task automatic chk_off(input string tag, input logic [15:0] word);
    total++;
    assert (dq !== word) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=not %h", tag, dq, word);
    end
  endtask

  // Drive one command for the next rising edge, return 1ns after that edge.
  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr,
                       input logic [15:0] d, input logic oe, input logic ml, input logic mh);
    ncs = 1'b0; {nras, ncas, nwe} = c; ba = b; a = addr;
    tb_dq = d; tb_oe = oe; dqml = ml; dqmh = mh;
    @(posedge clk); #1;
    ncs = 1'b1; {nras, ncas, nwe} = 3'b111; tb_oe = 1'b0; dqml = 1'b0; dqmh = 1'b0;
  endtask

  task automatic nop();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; #2;
    reset_n = 1'b1;
    nop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mode", 32'(mode_reg), 32'h0);
    chk("rst_init", 32'(initialized), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_code", 32'(err_code), 32'h0);
    chk("rst_ref", 32'(refresh_count), 32'h0);
    reset_n = 1'b1;
    nop();

    // ---- init, CL2
    issue(PRE, 2'd0, 13'h0400, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("init_after_pre", 32'(initialized), 32'h0);
    issue(LDM, 2'd0, 13'h0220, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("init_done", 32'(initialized), 32'h1);
    chk("init_mode", 32'(mode_reg), 32'h0220);
    chk("init_err", 32'(err), 32'h0);

    // ---- write with auto-precharge, reopen, read at CL2
    issue(ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(WR,  2'd1, 13'h0403, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    issue(ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("reopen_err", 32'(err), 32'h0);
    issue(RD,  2'd1, 13'h0003, 16'h0, 1'b0, 1'b0, 1'b0);
    nop();
    chk("rd_cl2_data", 32'(dq), 32'hBEEF);
    nop();
    chk_off("rd_cl2_release", 16'hBEEF);

    // ---- byte masks
    issue(WR, 2'd1, 13'h0003, 16'h1234, 1'b1, 1'b1, 1'b0);
    issue(RD, 2'd1, 13'h0003, 16'h0, 1'b0, 1'b0, 1'b0);
    nop();
    chk("mask_low", 32'(dq), 32'h12EF);
    nop();
    issue(WR, 2'd1, 13'h0003, 16'h5678, 1'b1, 1'b0, 1'b1);
    issue(WR, 2'd1, 13'h0004, 16'hCAFE, 1'b1, 1'b0, 1'b0);

    // ---- back-to-back reads
    issue(RD, 2'd1, 13'h0003, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(RD, 2'd1, 13'h0004, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("b2b_first_mask_high", 32'(dq), 32'h1278);
    nop();
    chk("b2b_second", 32'(dq), 32'hCAFE);
    nop();
    chk_off("b2b_release", 16'hCAFE);
    chk("b2b_err", 32'(err), 32'h0);

    // ---- refresh with all banks idle
    issue(PRE, 2'd0, 13'h0400, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) issue(REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("ref_count", 32'(refresh_count), 32'd3);
    chk("ref_err", 32'(err), 32'h0);

    // ---- violations: READ on IDLE bank, then ACTIVE on OPEN bank
    issue(RD, 2'd2, 13'h0003, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("idle_rd_err", 32'(err), 32'h1);
    chk("idle_rd_code", 32'(err_code), 32'd3);
    issue(ACT, 2'd0, 13'd5, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(ACT, 2'd0, 13'd5, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("first_code_kept", 32'(err_code), 32'd3);
    repeat (3) nop();

    // ---- reset, re-init at CL3, AUTO_REFRESH with a bank open
    do_reset();
    chk("rst2_err", 32'(err), 32'h0);
    chk("rst2_ref", 32'(refresh_count), 32'h0);
    chk("rst2_init", 32'(initialized), 32'h0);
    issue(PRE, 2'd0, 13'h0400, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(LDM, 2'd0, 13'h0230, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("cl3_mode", 32'(mode_reg), 32'h0230);
    issue(ACT, 2'd0, 13'd5, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("ref_open_err", 32'(err), 32'h1);
    chk("ref_open_code", 32'(err_code), 32'd5);
    chk("ref_open_count", 32'(refresh_count), 32'd1);

    // ---- reset, illegal LOAD_MODE (BL=1), then legal CL3
    do_reset();
    issue(PRE, 2'd0, 13'h0400, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(LDM, 2'd0, 13'h0221, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("bad_mode_code", 32'(err_code), 32'd6);
    chk("bad_mode_reg", 32'(mode_reg), 32'h0);
    chk("bad_mode_init", 32'(initialized), 32'h0);
    issue(LDM, 2'd0, 13'h0230, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("cl3_init", 32'(initialized), 32'h1);
    chk("cl3_mode2", 32'(mode_reg), 32'h0230);

    // ---- CL3 read: data valid at T+3
    issue(ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(RD,  2'd1, 13'h0003, 16'h0, 1'b0, 1'b0, 1'b0);
    chk_off("cl3_early_t1", 16'h1278);
    nop();
    chk_off("cl3_early_t2", 16'h1278);
    nop();
    chk("cl3_data", 32'(dq), 32'h1278);
    nop();
    chk_off("cl3_release", 16'h1278);

    // ---- reset while read data is on the bus
    issue(RD, 2'd1, 13'h0004, 16'h0, 1'b0, 1'b0, 1'b0);
    nop();
    nop();
    chk("cl3_pre_rst", 32'(dq), 32'hCAFE);
    reset_n = 1'b0; #1;
    chk_off("rst_dq_release", 16'hCAFE);
    chk("rst_mid_init", 32'(initialized), 32'h0);
    #1 reset_n = 1'b1;
    nop();
    chk_off("rst_flush", 16'hCAFE);

    // ---- array contents survive reset
    issue(PRE, 2'd0, 13'h0400, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(LDM, 2'd0, 13'h0220, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0, 1'b0);
    issue(RD,  2'd1, 13'h0004, 16'h0, 1'b0, 1'b0, 1'b0);
    nop();
    chk("retained", 32'(dq), 32'hCAFE);
    nop();
    chk("final_err", 32'(err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable single-chip SDR SDRAM responder (MT48LC16M16-style pin set) that answers the command stream issued by the core's SDRAM controller. It decodes ACTIVE/READ/WRITE/PRECHARGE/AUTO_REFRESH/LOAD_MODE, stores data in a small on-chip array, returns read data at the programmed CAS latency, and flags protocol violations. It sits on the board side of the SDRAM pins in simulation and FPGA loopback builds, and lets the controller be verified without external memory.

## Interface
- ROW_BITS, 13: row address width taken from SDRAM_A at ACTIVE.
- COL_BITS, 9: column address width taken from SDRAM_A at READ/WRITE.
- MEM_AW, 12: backing array depth 2^MEM_AW 16-bit words; index = low MEM_AW bits of {BA, row, col}.
- TRCD, 1: minimum clocks from ACTIVE to READ/WRITE on the same bank.

Ports:
- clk  in  1  memory clock; all pin sampling on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- SDRAM_DQ  inout  16  data bus; driven only during read data slots.
- SDRAM_A  in  13  multiplexed address.
- SDRAM_BA  in  2  bank select.
- SDRAM_DQML, SDRAM_DQMH  in  1 each  write byte masks (1 = byte not written).
- SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE  in  1 each  command.
- SDRAM_CKE  in  1  commands ignored while 0.
- mode_reg  out  13  last loaded mode register.
- initialized  out  1  init sequence complete.
- err  out  1  sticky protocol error.
- err_code  out  3  code of first error.
- refresh_count  out  16  AUTO_REFRESH count, saturating at 16'hFFFF.

## Operation
- Command = {nRAS,nCAS,nWE}, valid when nCS=0 and CKE=1; otherwise NOP. Encodings: 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO_REFRESH, 000 LOAD_MODE, 110 BURST_TERMINATE (accepted, no effect), 111 NOP.
- Per bank: state IDLE/OPEN, open row, TRCD down-counter loaded at ACTIVE.
- ACTIVE: bank IDLE -> OPEN, latch row = A[ROW_BITS-1:0].
- READ/WRITE: col = A[COL_BITS-1:0]; A10=1 auto-precharges the bank (back to IDLE after the access command).
- WRITE: DQ sampled on the same edge as the command; low byte written unless DQML=1, high byte unless DQMH=1.
- READ: array word enters a CL-deep pipeline; DQM ignored for reads.
- PRECHARGE: A10=1 closes all banks, else bank BA only; precharging an IDLE bank is legal.
- LOAD_MODE: mode_reg <= A; CL = A[6:4]; BL = A[2:0].
- Init FSM: WAIT_PRE -> WAIT_LDM on PRECHARGE with A10=1; WAIT_LDM -> READY on legal LOAD_MODE; initialized=1 in READY. LOAD_MODE is allowed again in READY.
- Error codes (first error latched; err stays 1 until reset): 1 ACTIVE/READ/WRITE before READY; 2 ACTIVE on OPEN bank; 3 READ/WRITE on IDLE bank; 4 READ/WRITE with TRCD counter nonzero; 5 AUTO_REFRESH/LOAD_MODE with any bank OPEN; 6 LOAD_MODE with CL not 2/3 or BL not 0; 7 WRITE while read data still pending on DQ (bus contention). A violating command still updates state except for code 6 (mode_reg unchanged).

## Timing
- Reset values: DQ high-Z, mode_reg 0, initialized 0, err 0, err_code 0, refresh_count 0, all banks IDLE, read pipeline empty, init FSM WAIT_PRE; array contents retained.
- READ sampled at edge T: DQ driven from just after edge T+CL-1 through edge T+CL, so it is valid at edge T+CL; high-Z otherwise.
- Back-to-back READs on consecutive edges give data on consecutive cycles.
- WRITE at edge T: read at edge T+1 or later returns the new data.
- ACTIVE at edge T: READ/WRITE is legal at edge T+TRCD or later.
- PRECHARGE or auto-precharge does not cancel in-flight read data.
- reset_n low mid-read: DQ released asynchronously and the pipeline is flushed.

## Test plan
- Init: PRECHARGE A=13'h0400, then LOAD_MODE A=13'h0220 -> initialized=1 one cycle after LOAD_MODE; mode_reg=13'h0220; err=0.
- Write/read: ACTIVE BA=1 row=5; WRITE col=3 A10=1 DQ=16'hBEEF; ACTIVE; READ col=3 at edge T -> DQ=16'hBEEF at edge T+2 and high-Z at T+3.
- Byte mask: over 16'hBEEF, WRITE 16'h1234 with DQML=1 -> read returns 16'h12EF.
- Violations: READ to IDLE bank -> err=1, err_code=3; a later ACTIVE on an OPEN bank leaves err_code=3.
- Refresh: 3 AUTO_REFRESH with all banks IDLE -> refresh_count=3. AUTO_REFRESH with a bank OPEN -> err_code=5.
- CL3 plus reset: LOAD_MODE A=13'h0230, READ at T -> data at T+3. Assert reset_n at T+2 -> DQ high-Z immediately, initialized=0, array data still readable after re-init.
